// File: rtl/sd_emmc_cmd_serdes_pkg.sv
// ---------------------------------------------------------------------------
// sd_emmc_cmd_serdes_pkg
//   Shared definitions for the eMMC CMD-line serializer/deserializer:
//   frame/response lengths, FSM state encoding and the serial CRC7 step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package sd_emmc_cmd_serdes_pkg;

    localparam logic [7:0] CMD_FRAME_LEN  = 8'd48;   // start..end bit of a command
    localparam logic [7:0] RESP_SHORT_LEN = 8'd48;   // R1/R3/R6
    localparam logic [7:0] RESP_LONG_LEN  = 8'd136;  // R2
    localparam logic [7:0] TOKEN_LEN      = 8'd40;   // bits covered by the command CRC

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_READ      = 3'd3,
        ST_TAIL      = 3'd4
    } cmd_state_e;

    // One serial step of CRC7, generator x^7 + x^3 + 1, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb        = bit_in ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/sd_emmc_crc7.sv
// ---------------------------------------------------------------------------
// sd_emmc_crc7
//   Serial CRC7 accumulator shared by the transmit and receive paths.
//   Ports:
//     clk    in  card clock
//     rst_n  in  asynchronous active-low reset
//     clr    in  synchronous clear (priority over en)
//     en     in  shift bit_i into the CRC this cycle
//     bit_i  in  serial data bit
//     crc_o  out current CRC7 remainder
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sd_emmc_crc7
    import sd_emmc_cmd_serdes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_r;

    // CRC remainder register: clear, accumulate or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 7'd0;
        end else if (clr) begin
            crc_r <= 7'd0;
        end else if (en) begin
            crc_r <= crc7_step(crc_r, bit_i);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_o = crc_r;

endmodule

// File: rtl/sd_emmc_cmd_serdes.sv
// ---------------------------------------------------------------------------
// sd_emmc_cmd_serdes
//   Serial CMD-line engine. Shifts a 48-bit command frame (40-bit token,
//   CRC7, end bit) onto CMD, then optionally captures an R1/R3/R6 (48-bit)
//   or R2 (136-bit) response and reports CRC/index status with a one-cycle
//   finish pulse.
//   Ports:
//     sd_clk      in   card clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     start_i     in   strobe: latch cmd_i/setting_i and start a frame
//     abort_i     in   abandon any transfer in progress
//     setting_i   in   {long_response, expect_response}
//     cmd_i       in   40-bit command token, bit 39 sent first
//     cmd_dat_i   in   CMD pin input
//     cmd_out_o   out  CMD pin output data
//     cmd_oe_o    out  CMD pin output enable
//     response_o  out  captured response, left-aligned at bit 119
//     crc_ok_o    out  received CRC7 matched
//     index_ok_o  out  received index matched the command index
//     finish_o    out  one-cycle transfer-complete pulse
//     busy_o      out  engine not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sd_emmc_cmd_serdes
    import sd_emmc_cmd_serdes_pkg::*;
#(
    parameter int NCR_MAX  = 64,
    parameter int NCC_TAIL = 8
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [1:0]   setting_i,
    input  logic [39:0]  cmd_i,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic [119:0] response_o,
    output logic         crc_ok_o,
    output logic         index_ok_o,
    output logic         finish_o,
    output logic         busy_o
);

    cmd_state_e     state_r;
    logic [7:0]     cnt_r;
    logic [39:0]    tok_r;
    logic           long_r;
    logic           expect_r;
    logic [5:0]     cmd_idx_r;
    logic [5:0]     rx_idx_r;
    logic [6:0]     rx_crc_r;
    logic           cmd_out_r;
    logic           cmd_oe_r;
    logic [119:0]   response_r;
    logic           crc_ok_r;
    logic           index_ok_r;
    logic           finish_r;

    logic           crc_clr_s;
    logic           crc_en_s;
    logic           crc_bit_s;
    logic [6:0]     crc_s;
    logic [6:0]     crc_nxt_s;
    logic           rd_idx_s;
    logic           rd_data_s;
    logic           rd_crc_s;
    logic           rd_last_s;

    sd_emmc_crc7 u_crc7 (
        .clk   (sd_clk),
        .rst_n (rst_n),
        .clr   (crc_clr_s),
        .en    (crc_en_s),
        .bit_i (crc_bit_s),
        .crc_o (crc_s)
    );

    // CRC including the token bit currently on the line; loaded as the
    // transmitted CRC on the cycle the last token bit is driven.
    assign crc_nxt_s = crc7_step(crc_s, cmd_out_r);

    // Response field decode by bit position after the start bit.
    // Short: 0 tx, 1..6 index, 7..38 payload, 39..45 crc, 46 end.
    // Long : 0 tx, 1..6 reserved, 7..126 R2[127:8], 127..133 crc, 134 end.
    always_comb begin
        rd_idx_s  = (!long_r) && (cnt_r >= 8'd1) && (cnt_r <= 8'd6);
        rd_data_s = long_r ? ((cnt_r >= 8'd7) && (cnt_r <= 8'd126))
                           : ((cnt_r >= 8'd7) && (cnt_r <= 8'd45));
        rd_crc_s  = long_r ? ((cnt_r >= 8'd127) && (cnt_r <= 8'd133))
                           : ((cnt_r >= 8'd39) && (cnt_r <= 8'd45));
        rd_last_s = long_r ? (cnt_r == (RESP_LONG_LEN - 8'd2))
                           : (cnt_r == (RESP_SHORT_LEN - 8'd2));
    end

    // CRC engine control: clear at frame start and before a response,
    // accumulate the transmitted token or the protected response bits.
    always_comb begin
        crc_clr_s = 1'b0;
        crc_en_s  = 1'b0;
        crc_bit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                crc_clr_s = start_i && !abort_i;
            end
            ST_WRITE: begin
                crc_en_s  = (cnt_r < TOKEN_LEN);
                crc_bit_s = cmd_out_r;
                crc_clr_s = (cnt_r == (CMD_FRAME_LEN - 8'd1));
            end
            ST_READ: begin
                // Short CRC also covers the start bit, which is a zero
                // shifted into a zero remainder and so needs no cycle.
                crc_en_s  = long_r ? rd_data_s : (cnt_r <= 8'd38);
                crc_bit_s = cmd_dat_i;
            end
            default: begin
                crc_clr_s = 1'b0;
            end
        endcase
    end

    // Main CMD-line FSM with registered pin and status outputs.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            tok_r      <= 40'd0;
            long_r     <= 1'b0;
            expect_r   <= 1'b0;
            cmd_idx_r  <= 6'd0;
            rx_idx_r   <= 6'd0;
            rx_crc_r   <= 7'd0;
            cmd_out_r  <= 1'b1;
            cmd_oe_r   <= 1'b0;
            response_r <= 120'd0;
            crc_ok_r   <= 1'b0;
            index_ok_r <= 1'b0;
            finish_r   <= 1'b0;
        end else if (abort_i && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            finish_r  <= 1'b0;
        end else begin
            finish_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        expect_r   <= setting_i[0];
                        long_r     <= setting_i[1];
                        cmd_idx_r  <= cmd_i[37:32];
                        cmd_out_r  <= cmd_i[39];
                        cmd_oe_r   <= 1'b1;
                        tok_r      <= {cmd_i[38:0], 1'b0};
                        cnt_r      <= 8'd0;
                        crc_ok_r   <= 1'b0;
                        index_ok_r <= 1'b0;
                        state_r    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // cnt_r is the index of the bit currently on CMD
                    cnt_r <= cnt_r + 8'd1;
                    if (cnt_r == (CMD_FRAME_LEN - 8'd1)) begin
                        cmd_oe_r  <= 1'b0;
                        cmd_out_r <= 1'b1;
                        cnt_r     <= 8'd0;
                        state_r   <= expect_r ? ST_WAIT_RESP : ST_TAIL;
                    end else if (cnt_r == (TOKEN_LEN - 8'd1)) begin
                        // Reload shifter with remaining CRC bits plus end bit
                        cmd_out_r <= crc_nxt_s[6];
                        tok_r     <= {crc_nxt_s[5:0], 1'b1, 33'd0};
                    end else begin
                        cmd_out_r <= tok_r[39];
                        tok_r     <= {tok_r[38:0], 1'b0};
                    end
                end
                ST_WAIT_RESP: begin
                    if (!cmd_dat_i) begin
                        cnt_r   <= 8'd0;
                        state_r <= ST_READ;
                    end else if (cnt_r == 8'(NCR_MAX - 1)) begin
                        cnt_r   <= 8'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_READ: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (rd_idx_s) begin
                        rx_idx_r <= {rx_idx_r[4:0], cmd_dat_i};
                    end
                    if (rd_data_s) begin
                        response_r <= {response_r[118:0], cmd_dat_i};
                    end
                    if (rd_crc_s) begin
                        rx_crc_r <= {rx_crc_r[5:0], cmd_dat_i};
                    end
                    if (rd_last_s) begin
                        // Short responses hold 39 bits (payload + crc) at the
                        // bottom of the shifter; move them to the top.
                        if (!long_r) begin
                            response_r <= {response_r[38:0], 81'd0};
                        end
                        crc_ok_r   <= (crc_s == rx_crc_r);
                        index_ok_r <= long_r ? 1'b1 : (rx_idx_r == cmd_idx_r);
                        cnt_r      <= 8'd0;
                        state_r    <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (cnt_r == 8'(NCC_TAIL - 1)) begin
                        finish_r <= 1'b1;
                        cnt_r    <= 8'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 8'd0;
                    cmd_out_r <= 1'b1;
                    cmd_oe_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_out_o  = cmd_out_r;
    assign cmd_oe_o   = cmd_oe_r;
    assign response_o = response_r;
    assign crc_ok_o   = crc_ok_r;
    assign index_ok_o = index_ok_r;
    assign finish_o   = finish_r;
    assign busy_o     = (state_r != ST_IDLE);

endmodule
